// File: rtl/wshbn_uart.sv
// Wishbone classic slave UART: 8N1 transmitter behind a TX FIFO, receiver with one-byte holding register.
// Define UART_PARITY_EN to add a parity bit (CTRL[2]: 1=odd, 0=even) to both directions.
module wshbn_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH     = 8
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_full,
  output logic        uart_empty,
  output logic        interrupt
);
  localparam int AW = (TX_DEPTH > 2) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = $clog2(TX_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic        ack_q, irq_q, rx_valid_q, ovr_q, ferr_q, tovf_q, perr_q;
  logic [31:0] dat_q, rdata, status;
  logic [2:0]  ctrl_q;
  logic [15:0] div_q;
  logic [7:0]  rx_byte_q;
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  state_t      tx_state_q, rx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q, rx_cnt_q, rx_div_q;
  logic [2:0]  tx_bit_q, rx_bit_q;
  logic [7:0]  tx_shift_q, rx_shift_q;
  logic        tx_q, rx_s1_q, rx_s2_q, rx_prev_q;
`ifdef UART_PARITY_EN
  logic        tx_par_q, rx_perr_q;
`endif

  logic       accept, wr, rd, push, pop, fifo_full, fifo_empty, tx_done_idle, rx_pop, rx_done;
  logic [1:0] sel;
  logic       unused_bits;

  assign accept       = CYC_I & STB_I & ~ack_q;
  assign wr           = accept & WE_I;
  assign rd           = accept & ~WE_I;
  assign sel          = ADR_I[3:2];
  assign fifo_full    = (cnt_q == CW'(TX_DEPTH));
  assign fifo_empty   = (cnt_q == '0);
  assign push         = wr & (sel == 2'd0) & ~fifo_full;
  assign pop          = (tx_state_q == S_IDLE) & ~fifo_empty;
  assign tx_done_idle = fifo_empty & (tx_state_q == S_IDLE);
  assign rx_pop       = rd & (sel == 2'd0) & rx_valid_q;
  assign rx_done      = (rx_state_q == S_STOP) && (rx_cnt_q == rx_div_q - 16'd1);
  assign unused_bits  = ^{DAT_I[31:16], ADR_I[1:0]};

  assign DAT_O      = dat_q;
  assign ACK_O      = ack_q;
  assign uart_tx    = tx_q;
  assign uart_full  = fifo_full;
  assign uart_empty = tx_done_idle;
  assign interrupt  = irq_q;

  always_comb begin
    status       = '0;
    status[0]    = rx_valid_q;
    status[1]    = fifo_full;
    status[2]    = tx_done_idle;
    status[3]    = ovr_q;
    status[4]    = ferr_q;
    status[5]    = tovf_q;
    status[6]    = perr_q;
    status[11:8] = 4'(cnt_q);
    case (sel)
      2'd0:    rdata = {24'b0, rx_valid_q ? rx_byte_q : 8'h00};
      2'd1:    rdata = status;
      2'd2:    rdata = {29'b0, ctrl_q};
      default: rdata = {16'b0, div_q};
    endcase
  end

  // Bus registers and sticky flags; receiver completion takes priority over W1C on the same edge.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q <= 1'b0; dat_q <= '0; irq_q <= 1'b0; ctrl_q <= '0; div_q <= 16'(CLKS_PER_BIT);
      rx_valid_q <= 1'b0; rx_byte_q <= '0;
      ovr_q <= 1'b0; ferr_q <= 1'b0; tovf_q <= 1'b0; perr_q <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= rd ? rdata : '0;
      irq_q <= (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & tx_done_idle);
      if (wr) begin
        case (sel)
          2'd0: if (fifo_full) tovf_q <= 1'b1;
          2'd1: begin
            if (DAT_I[3]) ovr_q  <= 1'b0;
            if (DAT_I[4]) ferr_q <= 1'b0;
            if (DAT_I[5]) tovf_q <= 1'b0;
            if (DAT_I[6]) perr_q <= 1'b0;
          end
`ifdef UART_PARITY_EN
          2'd2: ctrl_q <= DAT_I[2:0];
`else
          2'd2: ctrl_q <= {1'b0, DAT_I[1:0]};
`endif
          default: div_q <= (DAT_I[15:0] < 16'd4) ? 16'd4 : DAT_I[15:0];
        endcase
      end
      if (rx_pop) rx_valid_q <= 1'b0;
      if (rx_done) begin
        if (rx_valid_q & ~rx_pop) begin
          ovr_q <= 1'b1;
        end else begin
          rx_byte_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
          if (!rx_s2_q) ferr_q <= 1'b1;
`ifdef UART_PARITY_EN
          if (rx_perr_q) perr_q <= 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) tx_mem[wr_ptr_q] <= DAT_I[7:0];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push & ~pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop & ~push) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state_q <= S_IDLE; tx_q <= 1'b1; tx_cnt_q <= '0; tx_div_q <= '0;
      tx_bit_q <= '0; tx_shift_q <= '0;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            tx_shift_q <= tx_mem[rd_ptr_q];
`ifdef UART_PARITY_EN
            tx_par_q   <= ^tx_mem[rd_ptr_q] ^ ctrl_q[2];
`endif
            tx_div_q   <= div_q;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_q <= '0; tx_bit_q <= '0; tx_q <= tx_shift_q[0]; tx_state_q <= S_DATA;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_DATA: if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_q <= tx_par_q; tx_state_q <= S_PAR;
`else
            tx_q <= 1'b1; tx_state_q <= S_STOP;
`endif
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1; tx_shift_q <= tx_shift_q >> 1; tx_q <= tx_shift_q[1];
          end
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_PAR: if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_q <= '0; tx_q <= 1'b1; tx_state_q <= S_STOP;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        S_STOP: if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_q <= '0; tx_q <= 1'b1; tx_state_q <= S_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 16'd1;
        default: begin tx_state_q <= S_IDLE; tx_q <= 1'b1; end
      endcase
    end
  end

  // Start bit is re-checked half a bit after the falling edge, so later samples land mid-bit.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_state_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
`ifdef UART_PARITY_EN
      rx_perr_q <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        S_IDLE: if (rx_prev_q & ~rx_s2_q) begin
          rx_div_q <= div_q; rx_cnt_q <= '0; rx_state_q <= S_START;
`ifdef UART_PARITY_EN
          rx_perr_q <= 1'b0;
`endif
        end
        S_START: if (rx_cnt_q == {1'b0, rx_div_q[15:1]}) begin
          rx_cnt_q <= '0; rx_bit_q <= '0;
          rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_DATA: if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
          if (rx_bit_q == 3'd7) rx_state_q <= S_PAR;
`else
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
`endif
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_PAR: if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_q <= '0; rx_state_q <= S_STOP;
`ifdef UART_PARITY_EN
          rx_perr_q <= rx_s2_q ^ (^rx_shift_q) ^ ctrl_q[2];
`endif
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        S_STOP: if (rx_done) begin
          rx_cnt_q <= '0; rx_state_q <= S_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 16'd1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end
endmodule
